stopwatch_ctrl: RTL and testbench

//  Control FSM for the 1/100 s stopwatch. Sits between the debounced buttons,
//  the 10 ms tick and the BCD counter chain. Owns run/stop, lap (split) freeze,

---
 rtl/stopwatch_ctrl.sv | 105 ++++++++++
 tb/tb_stopwatch_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: run/stop, lap freeze, clear and overflow handling
// between the debounced buttons, the 10 ms tick and the BCD counter chain.
module stopwatch_ctrl #(
  parameter int unsigned DIGITS   = 4,
  parameter bit          OVF_STOP = 1'b1
) (
  input  logic                  clk,
  input  logic                  ss_nreset,
  input  logic                  tick,
  input  logic                  btn_ss_n,
  input  logic                  btn_lap_n,
  input  logic [4*DIGITS-1:0]   cnt_bcd,
  input  logic                  cnt_max,
  output logic                  cnt_inc,
  output logic                  cnt_clr,
  output logic [4*DIGITS-1:0]   disp_bcd,
  output logic                  running,
  output logic                  lap_active,
  output logic                  ovf
);

  typedef enum logic [2:0] {StIdle, StRun, StLap, StStop, StOvf} state_e;

  state_e                state_q, state_d;
  logic                  ss_prev_q, lap_prev_q;
  logic [4*DIGITS-1:0]   lap_reg_q;
  logic                  cnt_clr_q, cnt_clr_d;
  logic                  ovf_q, ovf_d;
  logic                  lap_load;
  logic                  ss_press, lap_press, max_tick;

  // Falling-edge detect; a simultaneous ss press drops the lap press.
  assign ss_press  = ss_prev_q & ~btn_ss_n;
  assign lap_press = lap_prev_q & ~btn_lap_n & ~ss_press;

  assign running    = (state_q == StRun) || (state_q == StLap);
  assign lap_active = (state_q == StLap);
  assign max_tick   = tick & cnt_max & running;
  assign cnt_inc    = tick & running & ~(OVF_STOP & cnt_max);
  assign cnt_clr    = cnt_clr_q;
  assign ovf        = ovf_q;
  assign disp_bcd   = lap_active ? lap_reg_q : cnt_bcd;

  // Next-state logic; overflow takes priority over button presses.
  always_comb begin
    state_d   = state_q;
    lap_load  = 1'b0;
    cnt_clr_d = 1'b0;
    ovf_d     = ovf_q | max_tick;
    unique case (state_q)
      StIdle: begin
        if (ss_press) state_d = StRun;
      end
      StRun: begin
        if (OVF_STOP && max_tick) state_d = StOvf;
        else if (ss_press)        state_d = StStop;
        else if (lap_press) begin
          state_d  = StLap;
          lap_load = 1'b1;
        end
      end
      StLap: begin
        if (OVF_STOP && max_tick) state_d = StOvf;
        else if (ss_press)        state_d = StStop;
        else if (lap_press)       state_d = StRun;
      end
      StStop: begin
        if (ss_press) state_d = StRun;
        else if (lap_press) begin
          state_d   = StIdle;
          cnt_clr_d = 1'b1;
          ovf_d     = 1'b0;
        end
      end
      StOvf: begin
        if (lap_press) begin
          state_d   = StIdle;
          cnt_clr_d = 1'b1;
          ovf_d     = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, button history, lap latch, clear pulse and sticky overflow.
  always_ff @(posedge clk or negedge ss_nreset) begin
    if (!ss_nreset) begin
      state_q    <= StIdle;
      ss_prev_q  <= 1'b1;
      lap_prev_q <= 1'b1;
      lap_reg_q  <= '0;
      cnt_clr_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ss_prev_q  <= btn_ss_n;
      lap_prev_q <= btn_lap_n;
      if (lap_load) lap_reg_q <= cnt_bcd;
      cnt_clr_q  <= cnt_clr_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: a behavioural BCD counter closes the loop
// for the OVF_STOP=1 instance; a second OVF_STOP=0 instance sees fixed counts.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        ss_nreset, tick, btn_ss_n, btn_lap_n;
  logic [15:0] cnt_bcd, disp_bcd, c0_bcd, disp0;
  logic        cnt_max, c0_max;
  logic        cnt_inc, cnt_clr, running, lap_active, ovf;
  logic        inc0, clr0, run0, lap0, ovf0;
  int          cnt, load_val, inc_cnt;
  logic        load;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DIGITS(4), .OVF_STOP(1'b1)) dut (
    .clk(clk), .ss_nreset(ss_nreset), .tick(tick), .btn_ss_n(btn_ss_n),
    .btn_lap_n(btn_lap_n), .cnt_bcd(cnt_bcd), .cnt_max(cnt_max), .cnt_inc(cnt_inc),
    .cnt_clr(cnt_clr), .disp_bcd(disp_bcd), .running(running),
    .lap_active(lap_active), .ovf(ovf)
  );

  stopwatch_ctrl #(.DIGITS(4), .OVF_STOP(1'b0)) dut0 (
    .clk(clk), .ss_nreset(ss_nreset), .tick(tick), .btn_ss_n(btn_ss_n),
    .btn_lap_n(btn_lap_n), .cnt_bcd(c0_bcd), .cnt_max(c0_max), .cnt_inc(inc0),
    .cnt_clr(clr0), .disp_bcd(disp0), .running(run0),
    .lap_active(lap0), .ovf(ovf0)
  );

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Behavioural counter chain driven by the DUT's inc/clr.
  always @(posedge clk or negedge ss_nreset) begin
    if (!ss_nreset)   cnt <= 0;
    else if (load)    cnt <= load_val;
    else if (cnt_clr) cnt <= 0;
    else if (cnt_inc) cnt <= (cnt == 9999) ? 0 : cnt + 1;
  end
  assign cnt_bcd = to_bcd(cnt);
  assign cnt_max = (cnt == 9999);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive just after the edge, return at the falling edge.
  task automatic step(input logic s, input logic l, input logic t);
    @(posedge clk);
    #1;
    btn_ss_n  = s;
    btn_lap_n = l;
    tick      = t;
    @(negedge clk);
    if (cnt_inc) inc_cnt++;
  endtask

  task automatic load_cnt(input int v);
    @(posedge clk);
    #1;
    load_val = v;
    load     = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  typedef struct {
    logic s, l, t;
    logic inc, clr, run, lap, ov;
    logic [15:0] disp;
  } vec_t;

  vec_t tbl[16];
  logic dropped;

  initial begin
    // ss  lap tick | inc clr run lap ovf | disp
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0001};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0002};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0002};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0002};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0005};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0005};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0006};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0006};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0006};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};

    ss_nreset = 1'b0;
    btn_ss_n  = 1'b1;
    btn_lap_n = 1'b1;
    tick      = 1'b0;
    load      = 1'b0;
    load_val  = 0;
    c0_bcd    = 16'h0000;
    c0_max    = 1'b0;
    inc_cnt   = 0;
    #3;
    check("rst running", running, 0);
    check("rst lap_active", lap_active, 0);
    check("rst ovf", ovf, 0);
    check("rst cnt_clr", cnt_clr, 0);
    check("rst disp", disp_bcd, 16'h0000);
    @(negedge clk);
    ss_nreset = 1'b1;

    // Press edges, lap freeze, dual press, clear from STOP.
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].s, tbl[i].l, tbl[i].t);
      check($sformatf("v%0d cnt_inc", i), cnt_inc, tbl[i].inc);
      check($sformatf("v%0d cnt_clr", i), cnt_clr, tbl[i].clr);
      check($sformatf("v%0d running", i), running, tbl[i].run);
      check($sformatf("v%0d lap_active", i), lap_active, tbl[i].lap);
      check($sformatf("v%0d ovf", i), ovf, tbl[i].ov);
      check($sformatf("v%0d disp", i), disp_bcd, tbl[i].disp);
    end

    // 150 ticks of running, then stop.
    inc_cnt = 0;
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 150; i++) step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("run150 inc count", inc_cnt, 150);
    check("run150 stopped", running, 0);
    check("run150 disp", disp_bcd, 16'h0150);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b1);
      check($sformatf("stop tick%0d cnt_inc", i), cnt_inc, 0);
    end
    check("stop disp held", disp_bcd, 16'h0150);

    // Clear from STOP: exactly one clr cycle.
    step(1'b1, 1'b0, 1'b0);
    check("clr pre", cnt_clr, 0);
    step(1'b1, 1'b1, 1'b0);
    check("clr pulse", cnt_clr, 1);
    check("clr ovf", ovf, 0);
    step(1'b1, 1'b1, 1'b0);
    check("clr single", cnt_clr, 0);
    check("clr disp", disp_bcd, 16'h0000);

    // Held start/stop gives a single transition.
    step(1'b0, 1'b1, 1'b0);
    dropped = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (!running) dropped = 1'b1;
    end
    check("hold running", running, 1);
    check("hold no toggle", dropped, 0);
    step(1'b1, 1'b1, 1'b0);

    // Overflow: stop-and-hold instance vs wrapping instance.
    c0_bcd = 16'h9999;
    c0_max = 1'b1;
    load_cnt(9999);
    step(1'b1, 1'b1, 1'b1);
    check("ovf1 no inc", cnt_inc, 0);
    check("ovf0 inc", inc0, 1);
    step(1'b1, 1'b1, 1'b0);
    check("ovf1 running", running, 0);
    check("ovf1 flag", ovf, 1);
    check("ovf1 disp", disp_bcd, 16'h9999);
    check("ovf0 running", run0, 1);
    check("ovf0 flag", ovf0, 1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("ovf1 ss ignored", running, 0);
    check("ovf1 flag held", ovf, 1);
    check("ovf0 stopped", run0, 0);
    check("ovf0 sticky", ovf0, 1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("ovf1 clr", cnt_clr, 1);
    check("ovf1 cleared", ovf, 0);
    check("ovf0 clr", clr0, 1);
    check("ovf0 cleared", ovf0, 0);
    step(1'b1, 1'b1, 1'b0);
    check("ovf1 disp zero", disp_bcd, 16'h0000);
    c0_bcd = 16'h0000;
    c0_max = 1'b0;

    // Async reset while in LAP.
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("lap entry", lap_active, 1);
    check("lap disp", disp_bcd, 16'h0001);
    step(1'b1, 1'b1, 1'b1);
    #2;
    ss_nreset = 1'b0;
    #1;
    check("arst cnt_inc", cnt_inc, 0);
    check("arst running", running, 0);
    check("arst lap_active", lap_active, 0);
    check("arst ovf", ovf, 0);
    check("arst cnt_clr", cnt_clr, 0);
    check("arst disp", disp_bcd, 16'h0000);
    tick = 1'b0;
    @(negedge clk);
    ss_nreset = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    check("post rst idle", running, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
